// File: rtl/cardiv_pkg.sv
// Shared types and constants for the carry-less divider.
package cardiv_pkg;

    localparam int unsigned CDV_XLEN  = 32;
    localparam int unsigned CDV_CNT_W = 6;

    typedef enum logic [1:0] {
        CDV_CLDIV = 2'd0,
        CDV_CLREM = 2'd1
    } f_part;

    localparam logic [CDV_CNT_W-1:0] CDV_IDLE     = 6'd0;
    localparam logic [CDV_CNT_W-1:0] CDV_DONE     = 6'b111111;
    localparam logic [CDV_XLEN-1:0]  CDV_BAD_FUNC = 32'd1337;

    // Datapath registers (everything except the step counter)
    typedef struct packed {
        logic [CDV_XLEN-1:0]  rem;
        logic [CDV_XLEN-1:0]  quo;
        logic [CDV_XLEN-1:0]  div;
        logic [CDV_CNT_W-1:0] last;
    } cdv_dp_t;

endpackage

// File: rtl/cardiv_lzc.sv
// 32-bit leading-zero counter; returns 32 for an all-zero input.
module cardiv_lzc
    import cardiv_pkg::*;
(
    input  logic [CDV_XLEN-1:0]  i_data,
    output logic [CDV_CNT_W-1:0] o_count
);

    // Ascending scan: the highest set bit is the last one to write o_count
    always_comb begin
        o_count = CDV_CNT_W'(CDV_XLEN);
        for (int i = 0; i < CDV_XLEN; i++) begin
            if (i_data[i]) begin
                o_count = CDV_CNT_W'(CDV_XLEN - 1 - i);
            end
        end
    end

endmodule

// File: rtl/cardiv.sv
// Iterative GF(2) polynomial divider: one reduction step per cycle,
// quotient or remainder selected onto the result port.
module cardiv
    import cardiv_pkg::*;
(
    input  logic                s_clk_i,
    input  logic                s_resetn_i,
    input  logic [1:0]          s_function_i,
    input  logic [CDV_XLEN-1:0] s_op1_i,
    input  logic [CDV_XLEN-1:0] s_op2_i,
    input  logic                s_stall_i,
    input  logic                s_flush_i,
    input  logic                s_compute_i,
    output logic                s_finished_o,
    output logic [CDV_XLEN-1:0] s_result_o
);

    logic [CDV_CNT_W-1:0] r_cnt;
    logic [CDV_CNT_W-1:0] w_cnt_nxt;
    cdv_dp_t              r_dp;
    cdv_dp_t              w_dp_nxt;
    logic                 w_dp_we;
    logic [CDV_CNT_W-1:0] w_lzc;
    logic [CDV_CNT_W-1:0] w_j;
    logic [4:0]           w_bitpos;
    logic [4:0]           w_qpos;
    logic                 w_sub;
    logic [CDV_XLEN-1:0]  w_rem_step;

    cardiv_lzc u_lzc (
        .i_data  (s_op2_i),
        .o_count (w_lzc)
    );

    // Step j tests remainder bit 31-j and sets quotient bit rlast-j
    always_comb begin
        w_j        = r_cnt - 6'd1;
        w_bitpos   = 5'(6'd31 - w_j);
        w_qpos     = 5'(r_dp.last - w_j);
        w_sub      = r_dp.rem[w_bitpos];
        w_rem_step = w_sub ? (r_dp.rem ^ r_dp.div) : r_dp.rem;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dp_nxt  = r_dp;
        w_dp_we   = s_compute_i;

        if (s_flush_i) begin
            w_cnt_nxt = CDV_IDLE;
        end else if (r_cnt == CDV_IDLE) begin
            if (s_compute_i) begin
                w_dp_nxt.last = w_lzc;
                w_dp_nxt.div  = s_op2_i << w_lzc;
                w_dp_nxt.rem  = s_op1_i;
                w_dp_nxt.quo  = '0;
                if ((s_op2_i == '0) || (s_op1_i == '0)) begin
                    w_cnt_nxt = CDV_DONE;
                end else begin
                    w_cnt_nxt = 6'd1;
                end
            end
        end else if (r_cnt == CDV_DONE) begin
            // Result is held under stall, otherwise retire to idle
            if (!s_stall_i) begin
                w_cnt_nxt = CDV_IDLE;
                w_dp_nxt  = '0;
                w_dp_we   = 1'b1;
            end
        end else if (s_compute_i) begin
            w_dp_nxt.rem = w_rem_step;
            if (w_sub) begin
                w_dp_nxt.quo = r_dp.quo | (32'd1 << w_qpos);
            end
            w_dp_nxt.div = r_dp.div >> 1;
            if ((w_j == r_dp.last) || (w_rem_step == '0)) begin
                w_cnt_nxt = CDV_DONE;
            end else begin
                w_cnt_nxt = r_cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_cnt <= CDV_IDLE;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (w_dp_we) begin
            r_dp <= w_dp_nxt;
        end
    end

    assign s_finished_o = (r_cnt == CDV_DONE);

    always_comb begin
        case (s_function_i)
            CDV_CLDIV: s_result_o = r_dp.quo;
            CDV_CLREM: s_result_o = r_dp.rem;
            default:   s_result_o = CDV_BAD_FUNC;
        endcase
    end

endmodule

// File: tb/tb_cardiv.sv
// Randomized bench for cardiv against a degree-driven polynomial long-division model.
module tb_cardiv;
    import cardiv_pkg::*;

    logic        s_clk_i;
    logic        s_resetn_i;
    logic [1:0]  s_function_i;
    logic [31:0] s_op1_i;
    logic [31:0] s_op2_i;
    logic        s_stall_i;
    logic        s_flush_i;
    logic        s_compute_i;
    logic        s_finished_o;
    logic [31:0] s_result_o;

    int          vectors;
    int          errors;
    logic        exp_armed;
    logic [31:0] exp_q;
    logic [31:0] exp_r;

    cardiv dut (
        .s_clk_i      (s_clk_i),
        .s_resetn_i   (s_resetn_i),
        .s_function_i (s_function_i),
        .s_op1_i      (s_op1_i),
        .s_op2_i      (s_op2_i),
        .s_stall_i    (s_stall_i),
        .s_flush_i    (s_flush_i),
        .s_compute_i  (s_compute_i),
        .s_finished_o (s_finished_o),
        .s_result_o   (s_result_o)
    );

    initial s_clk_i = 1'b0;
    always #5 s_clk_i = ~s_clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pdeg(input logic [31:0] v);
        int d;
        d = -1;
        for (int i = 0; i < 32; i++) if (v[i]) d = i;
        return d;
    endfunction

    // Schoolbook division: cancel the leading term of the remainder each pass
    function automatic void pdiv(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
        int db;
        q = '0;
        r = a;
        if (b != '0) begin
            db = pdeg(b);
            for (int d = 31; d >= db; d--) begin
                if (r[d]) begin
                    r = r ^ (b << (d - db));
                    q[d - db] = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) if (a[i]) acc = acc ^ ({32'd0, b} << i);
        return acc;
    endfunction

    // Output checker: whenever a result is presented it must match the model
    always @(negedge s_clk_i) begin
        if (s_resetn_i && s_finished_o) begin
            if (!exp_armed) begin
                chk("spurious_finish", {31'd0, s_finished_o}, 32'd0);
            end else begin
                case (s_function_i)
                    2'd0:    chk("quotient", s_result_o, exp_q);
                    2'd1:    chk("remainder", s_result_o, exp_r);
                    default: chk("bad_func", s_result_o, 32'd1337);
                endcase
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stall_n, input int exp_lat);
        int          lat;
        int          bound;
        logic        done;
        logic [31:0] qd;
        logic [31:0] rd;
        logic [63:0] prod;
        pdiv(a, b, exp_q, exp_r);
        bound = ((a == '0) || (b == '0)) ? 1 : 33 - pdeg(b);
        chk("idle_before_start", {31'd0, s_finished_o}, 32'd0);
        exp_armed    = 1'b1;
        s_op1_i      = a;
        s_op2_i      = b;
        s_compute_i  = 1'b1;
        s_function_i = 2'($urandom_range(0, 3));
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge s_clk_i); #1;
            lat++;
            s_op1_i      = $urandom;
            s_op2_i      = $urandom;
            s_function_i = 2'($urandom_range(0, 3));
            if (s_finished_o) done = 1'b1;
        end
        if (!done) begin
            chk("finish_timeout", 32'(lat), 32'(bound));
        end else begin
            chk("latency_bound", 32'(lat <= bound), 32'd1);
            if (exp_lat >= 0) chk("latency_exact", 32'(lat), 32'(exp_lat));
            s_stall_i    = (stall_n > 0);
            s_function_i = CDV_CLDIV;
            #1 qd = s_result_o;
            s_function_i = CDV_CLREM;
            #1 rd = s_result_o;
            prod = clmul(qd, b);
            chk("invariant", prod[31:0] ^ rd, a);
            chk("product_width", prod[63:32], 32'd0);
            if (b != '0) chk("rem_degree", 32'(pdeg(rd) < pdeg(b)), 32'd1);
            s_function_i = 2'($urandom_range(0, 3));
            for (int k = 0; k < stall_n; k++) begin
                @(posedge s_clk_i); #1;
                chk("stall_hold", {31'd0, s_finished_o}, 32'd1);
                s_function_i = 2'($urandom_range(0, 3));
            end
            s_stall_i   = 1'b0;
            s_compute_i = 1'b0;
            @(posedge s_clk_i); #1;
            chk("finish_drop", {31'd0, s_finished_o}, 32'd0);
        end
        exp_armed = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mq;
        logic [31:0] mr;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        vectors      = 0;
        errors       = 0;
        exp_armed    = 1'b0;
        exp_q        = '0;
        exp_r        = '0;
        s_resetn_i   = 1'b0;
        s_function_i = CDV_CLDIV;
        s_op1_i      = '0;
        s_op2_i      = '0;
        s_stall_i    = 1'b0;
        s_flush_i    = 1'b0;
        s_compute_i  = 1'b0;

        // Hand-computed pins for the reference model
        pdiv(32'h5, 32'h3, mq, mr);
        chk("model_5_3_q", mq, 32'h3);
        chk("model_5_3_r", mr, 32'h0);
        pdiv(32'h7, 32'h3, mq, mr);
        chk("model_7_3_q", mq, 32'h2);
        chk("model_7_3_r", mr, 32'h1);
        pdiv(32'h1234, 32'h0, mq, mr);
        chk("model_div0_q", mq, 32'h0);
        chk("model_div0_r", mr, 32'h1234);
        pdiv(32'hFFFFFFFF, 32'h1, mq, mr);
        chk("model_ones_q", mq, 32'hFFFFFFFF);
        chk("model_ones_r", mr, 32'h0);
        pdiv(32'hDEADBEEF, 32'h80000001, mq, mr);
        chk("model_top_q", mq, 32'h1);
        chk("model_top_r", mr, 32'h5EADBEEE);

        repeat (3) @(posedge s_clk_i);
        #1 chk("reset_finished", {31'd0, s_finished_o}, 32'd0);
        s_resetn_i = 1'b1;
        @(posedge s_clk_i); #1;
        chk("idle_after_reset", {31'd0, s_finished_o}, 32'd0);

        run_op(32'h5, 32'h3, 0, -1);
        run_op(32'h7, 32'h3, 1, -1);
        run_op(32'h1234, 32'h0, 1, 1);
        run_op(32'h0, 32'h5, 0, 1);
        run_op(32'hFFFFFFFF, 32'h1, 4, 33);
        run_op(32'hDEADBEEF, 32'h80000001, 2, 2);

        // Flush mid-run, then a fresh operation on the same divisor
        s_op1_i     = 32'hDEADBEEF;
        s_op2_i     = 32'h11B;
        s_compute_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge s_clk_i); #1;
            chk("flush_prerun", {31'd0, s_finished_o}, 32'd0);
        end
        s_flush_i = 1'b1;
        @(posedge s_clk_i); #1;
        chk("flush_finished", {31'd0, s_finished_o}, 32'd0);
        s_flush_i   = 1'b0;
        s_compute_i = 1'b0;
        @(posedge s_clk_i); #1;
        chk("flush_idle", {31'd0, s_finished_o}, 32'd0);
        run_op(32'hABCD, 32'h11B, 1, -1);

        // Flush and start requested together: flush wins
        s_op1_i     = 32'h1234;
        s_op2_i     = 32'h0;
        s_compute_i = 1'b1;
        s_flush_i   = 1'b1;
        @(posedge s_clk_i); #1;
        chk("flush_vs_start", {31'd0, s_finished_o}, 32'd0);
        s_flush_i   = 1'b0;
        s_compute_i = 1'b0;
        @(posedge s_clk_i); #1;

        // Asynchronous reset while running
        s_op1_i     = 32'hFFFFFFFF;
        s_op2_i     = 32'h1;
        s_compute_i = 1'b1;
        repeat (10) @(posedge s_clk_i);
        #1 s_resetn_i = 1'b0;
        #1 chk("reset_midrun", {31'd0, s_finished_o}, 32'd0);
        s_compute_i = 1'b0;
        @(posedge s_clk_i); #1;
        s_resetn_i = 1'b1;
        @(posedge s_clk_i); #1;
        chk("reset_no_result", {31'd0, s_finished_o}, 32'd0);

        // Asynchronous reset while a stalled result is held
        pdiv(32'h5, 32'h3, exp_q, exp_r);
        exp_armed   = 1'b1;
        s_op1_i     = 32'h5;
        s_op2_i     = 32'h3;
        s_compute_i = 1'b1;
        s_stall_i   = 1'b1;
        lat = 0;
        while (!s_finished_o && lat < 40) begin
            @(posedge s_clk_i); #1;
            lat++;
        end
        chk("stall_reset_reach", {31'd0, s_finished_o}, 32'd1);
        @(posedge s_clk_i); #1;
        chk("stall_reset_hold", {31'd0, s_finished_o}, 32'd1);
        s_resetn_i = 1'b0;
        #1 chk("reset_while_done", {31'd0, s_finished_o}, 32'd0);
        exp_armed   = 1'b0;
        s_stall_i   = 1'b0;
        s_compute_i = 1'b0;
        @(posedge s_clk_i); #1;
        s_resetn_i = 1'b1;
        @(posedge s_clk_i); #1;

        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 15))
                0:       b = '0;
                1:       a = '0;
                2:       a = a >> $urandom_range(0, 31);
                3:       b = b | 32'h80000000;
                default: ;
            endcase
            run_op(a, b, $urandom_range(0, 3), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
